// File: rtl/pipeline_exec_ctrl.sv
// rtl/pipeline_exec_ctrl.sv - run/step/clear sequencer and hazard-merged stage enables for the 5-stage pipeline
// Optional feature macro: PIPE_EXEC_CTRL_CYCLE_CNT_EN (saturating executed-cycle counter)
module pipeline_exec_ctrl #(
  parameter int CNT_SZ     = 32,
  parameter int CLR_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt_wb,
  input  logic              i_load_hazard,
  input  logic              i_branch_taken,
  output logic              o_pc_enable,
  output logic              o_if_id_enable,
  output logic              o_id_ex_enable,
  output logic              o_ex_mem_enable,
  output logic              o_mem_wb_enable,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_pipe_clear,
  output logic              o_step_done,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [CNT_SZ-1:0] o_cycle_count
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_CLEAR  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CLR_W-1:0]  clr_cnt;
  logic              step_done_q;
  logic              cmd_fire;
  logic              advancing;
  logic              clear_entry;

  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign advancing   = (state == S_RUN) || (state == S_STEP);
  assign clear_entry = (state_nxt == S_CLEAR) && (state != S_CLEAR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      step_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      step_done_q <= (state == S_STEP);
      if (clear_entry)
        clr_cnt <= CLR_W'(CLR_CYCLES - 1);
      else if (state == S_CLEAR && clr_cnt != '0)
        clr_cnt <= clr_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    o_cmd_ready     = 1'b0;
    o_pc_enable     = 1'b0;
    o_if_id_enable  = 1'b0;
    o_id_ex_enable  = 1'b0;
    o_ex_mem_enable = 1'b0;
    o_mem_wb_enable = 1'b0;
    o_if_id_flush   = 1'b0;
    o_id_ex_flush   = 1'b0;

    case (state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (cmd_fire) begin
          case (i_cmd)
            CMD_RUN:   state_nxt = S_RUN;
            CMD_STEP:  state_nxt = S_STEP;
            CMD_CLEAR: state_nxt = S_CLEAR;
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        o_cmd_ready = 1'b1;
        // HALT reaching WB outranks any command on the same edge
        if (i_halt_wb)
          state_nxt = S_HALTED;
        else if (cmd_fire && i_cmd == CMD_CLEAR)
          state_nxt = S_CLEAR;
        else if (cmd_fire && i_cmd == 2'b10)
          state_nxt = S_IDLE;
      end
      S_STEP:   state_nxt = i_halt_wb ? S_HALTED : S_IDLE;
      S_CLEAR:  if (clr_cnt == '0) state_nxt = S_IDLE;
      S_HALTED: begin
        o_cmd_ready = 1'b1;
        if (cmd_fire && i_cmd == CMD_CLEAR)
          state_nxt = S_CLEAR;
      end
      default:  state_nxt = S_IDLE;
    endcase

    if (advancing) begin
      o_pc_enable     = 1'b1;
      o_if_id_enable  = 1'b1;
      o_id_ex_enable  = 1'b1;
      o_ex_mem_enable = 1'b1;
      o_mem_wb_enable = 1'b1;
      // a stalled cycle suppresses the branch flush; ID re-resolves it next cycle
      if (i_load_hazard) begin
        o_pc_enable    = 1'b0;
        o_if_id_enable = 1'b0;
        o_id_ex_flush  = 1'b1;
      end else if (i_branch_taken) begin
        o_if_id_flush  = 1'b1;
      end
    end
  end

  assign o_pipe_clear = (state == S_CLEAR);
  assign o_halted     = (state == S_HALTED);
  assign o_step_done  = step_done_q;
  assign o_state      = state;

`ifdef PIPE_EXEC_CTRL_CYCLE_CNT_EN
  logic [CNT_SZ-1:0] cycle_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || clear_entry)
      cycle_count <= '0;
    else if (advancing && cycle_count != '1)
      cycle_count <= cycle_count + 1'b1;
  end

  assign o_cycle_count = cycle_count;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// tb/tb_pipeline_exec_ctrl.sv - scoreboard bench for pipeline_exec_ctrl (CNT_SZ=4, CLR_CYCLES=2)
module tb_pipeline_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       halt_wb, load_hazard, branch_taken;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_fl, id_ex_fl, pipe_clear, step_done, halted;
  logic [2:0] state;
  logic [3:0] cycle_count;

  localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, STOP = 2'b10, CLEAR = 2'b11;

  pipeline_exec_ctrl #(.CNT_SZ(4), .CLR_CYCLES(2)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
    .i_halt_wb(halt_wb), .i_load_hazard(load_hazard), .i_branch_taken(branch_taken),
    .o_pc_enable(pc_en), .o_if_id_enable(if_id_en), .o_id_ex_enable(id_ex_en),
    .o_ex_mem_enable(ex_mem_en), .o_mem_wb_enable(mem_wb_en),
    .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl),
    .o_pipe_clear(pipe_clear), .o_step_done(step_done), .o_halted(halted),
    .o_state(state), .o_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]     v;
    logic [8*12-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  wire [17:0] act = {cmd_ready, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_fl, id_ex_fl, pipe_clear, step_done, halted, state, cycle_count};

  function automatic logic [3:0] ec(input int n);
`ifdef PIPE_EXEC_CTRL_CYCLE_CNT_EN
    return (n > 15) ? 4'd15 : 4'(n);
`else
    return 4'd0;
`endif
  endfunction

  task automatic drv(input logic r, input logic v, input logic [1:0] c,
                     input logic h, input logic lh, input logic br);
    @(posedge clk);
    #1;
    rst = r; cmd_valid = v; cmd = c; halt_wb = h; load_hazard = lh; branch_taken = br;
  endtask

  task automatic ex(input logic [8*12-1:0] tag, input logic rdy, input logic [4:0] en,
                    input logic [1:0] fl, input logic clr, input logic sd, input logic hl,
                    input logic [2:0] st, input int n);
    exp_t e;
    e.v   = {rdy, en, fl, clr, sd, hl, st, ec(n)};
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.tag, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = RUN; halt_wb = 1'b0; load_hazard = 1'b0; branch_taken = 1'b0;
    drv(1, 0, RUN, 0, 0, 0);
    drv(1, 0, RUN, 0, 0, 0);

    // three single steps
    drv(0, 1, STEP, 0, 0, 0); ex("reset",     1, 5'h00, 2'b00, 0, 0, 0, 3'd0, 0);
    drv(0, 0, RUN,  0, 0, 0); ex("step1",     0, 5'h1f, 2'b00, 0, 0, 0, 3'd2, 0);
    drv(0, 1, STEP, 0, 0, 0); ex("step1_done",1, 5'h00, 2'b00, 0, 1, 0, 3'd0, 1);
    drv(0, 0, RUN,  0, 0, 0); ex("step2",     0, 5'h1f, 2'b00, 0, 0, 0, 3'd2, 1);
    drv(0, 1, STEP, 0, 0, 0); ex("step2_done",1, 5'h00, 2'b00, 0, 1, 0, 3'd0, 2);
    drv(0, 0, RUN,  0, 0, 0); ex("step3",     0, 5'h1f, 2'b00, 0, 0, 0, 3'd2, 2);
    drv(0, 0, RUN,  0, 0, 0); ex("step3_done",1, 5'h00, 2'b00, 0, 1, 0, 3'd0, 3);

    // run with hazards, then halt beating a simultaneous stop
    drv(0, 1, RUN,  0, 0, 0); ex("idle",      1, 5'h00, 2'b00, 0, 0, 0, 3'd0, 3);
    drv(0, 0, RUN,  0, 0, 0); ex("run",       1, 5'h1f, 2'b00, 0, 0, 0, 3'd1, 3);
    drv(0, 0, RUN,  0, 1, 0); ex("load",      1, 5'h07, 2'b01, 0, 0, 0, 3'd1, 4);
    drv(0, 0, RUN,  0, 1, 1); ex("load_br",   1, 5'h07, 2'b01, 0, 0, 0, 3'd1, 5);
    drv(0, 0, RUN,  0, 0, 1); ex("branch",    1, 5'h1f, 2'b10, 0, 0, 0, 3'd1, 6);
    drv(0, 1, STOP, 1, 0, 0); ex("halt_stop", 1, 5'h1f, 2'b00, 0, 0, 0, 3'd1, 7);
    drv(0, 1, RUN,  0, 0, 0); ex("halted",    1, 5'h00, 2'b00, 0, 0, 1, 3'd4, 8);
    drv(0, 1, STEP, 0, 0, 0); ex("halt_run",  1, 5'h00, 2'b00, 0, 0, 1, 3'd4, 8);
    drv(0, 1, CLEAR,0, 0, 0); ex("halt_step", 1, 5'h00, 2'b00, 0, 0, 1, 3'd4, 8);
    drv(0, 0, RUN,  0, 0, 0); ex("clear1",    0, 5'h00, 2'b00, 1, 0, 0, 3'd3, 0);
    drv(0, 0, RUN,  0, 0, 0); ex("clear2",    0, 5'h00, 2'b00, 1, 0, 0, 3'd3, 0);

    // counter saturation at 4 bits, then reset mid-run
    drv(0, 1, RUN,  0, 0, 0); ex("clear_done",1, 5'h00, 2'b00, 0, 0, 0, 3'd0, 0);
    for (int k = 0; k < 20; k++) begin
      drv(0, 0, RUN, 0, 0, 0); ex("sat",      1, 5'h1f, 2'b00, 0, 0, 0, 3'd1, k);
    end
    drv(1, 0, RUN,  0, 0, 0); ex("sat_hold",  1, 5'h1f, 2'b00, 0, 0, 0, 3'd1, 20);
    drv(0, 0, RUN,  0, 0, 0); ex("reset_run", 1, 5'h00, 2'b00, 0, 0, 0, 3'd0, 0);

    // stop: the accepting edge still advances
    drv(0, 1, RUN,  0, 0, 0); ex("stop_idle", 1, 5'h00, 2'b00, 0, 0, 0, 3'd0, 0);
    drv(0, 1, STOP, 0, 0, 0); ex("stop_run",  1, 5'h1f, 2'b00, 0, 0, 0, 3'd1, 0);
    drv(0, 0, RUN,  0, 0, 0); ex("stopped",   1, 5'h00, 2'b00, 0, 0, 0, 3'd0, 1);

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    end else begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    end
    $finish;
  end

endmodule
